audio_in_deserializer: RTL and testbench
========================================

AUDIO_IN_DESERIALIZER -- requirements
Module: audio_in_deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, meaning bits per channel word captured (1..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning stereo-pair entries buffered (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port bit_clk_rising_edge  input  1  one-clk pulse, serial bit sample point.
REQ-006 SHALL have port left_right_clk_rising_edge  input  1  one-clk pulse, end of left word / start of right word.
REQ-007 SHALL have port left_right_clk_falling_edge  input  1  one-clk pulse, end of right word / start of left word.
REQ-008 SHALL have port counting  input  1  high while the bit counter reports the active bit window.
REQ-009 SHALL have port serial_audio_in_data  input  1  ADC serial data, MSB first.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the head entry this cycle.
REQ-011 SHALL have port overflow_clear  input  1  clears the sticky overflow flag.
REQ-012 SHALL have port out_valid  output  1  FIFO not empty.
REQ-013 SHALL have port out_left  output  DATA_WIDTH  left word of the head entry.
REQ-014 SHALL have port out_right  output  DATA_WIDTH  right word of the head entry.
REQ-015 SHALL have port fill_level  output  log2(FIFO_DEPTH)+1  entries currently held.
REQ-016 SHALL have port overflow  output  1  sticky: a completed pair was dropped.

Function
REQ-017 SHALL capture serial_audio_in_data only on cycles where bit_clk_rising_edge=1, counting=1, and no LR edge pulse is present.
REQ-018 SHALL write the k-th captured bit of a word (k=0 first) into bit DATA_WIDTH-1-k of the shift word; bits with k>=DATA_WIDTH SHALL be ignored.
REQ-019 SHALL pad words shorter than DATA_WIDTH bits with zeros in the LSBs.
REQ-020 SHALL, on left_right_clk_rising_edge, copy the shift word into left_hold, set left_hold_valid, clear the shift word and the bit index.
REQ-021 SHALL, on left_right_clk_falling_edge with left_hold_valid=1, push {left_hold, shift word} into the FIFO, then clear left_hold_valid, the shift word and the bit index.
REQ-022 SHALL, on left_right_clk_falling_edge with left_hold_valid=0 (first frame after reset), discard the shift word and push nothing.
REQ-023 SHALL use pre-edge register contents for boundary actions; a bit coinciding with an LR edge SHALL be discarded.
REQ-024 SHALL present the head entry show-ahead: out_left/out_right valid whenever out_valid=1, with no read latency.
REQ-025 SHALL pop the head on out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
REQ-026 SHALL make a pushed pair visible on out_valid/fill_level the cycle after the push.
REQ-027 SHALL, on push while full without a same-cycle pop, drop the new pair, keep contents unchanged, and set overflow.
REQ-028 SHALL, on simultaneous push and pop while full, accept both; fill_level stays FIFO_DEPTH and overflow is not set.
REQ-029 SHALL, on simultaneous push and pop at any level, keep fill_level unchanged.
REQ-030 SHALL wrap read and write pointers modulo FIFO_DEPTH.
REQ-031 SHALL clear overflow on overflow_clear=1 unless a drop occurs in that same cycle; the drop SHALL win.

Reset
REQ-032 SHALL, on reset=1, empty the FIFO and force out_valid=0, fill_level=0, overflow=0.
REQ-033 SHALL, on reset=1, clear left_hold_valid, the shift word and the bit index.
REQ-034 SHALL drive out_left and out_right to 0 while reset is asserted.
REQ-035 SHALL discard any partially captured frame when reset is asserted mid-word.

Verification
REQ-036 SHALL cover: after reset, LR falling, 24 bits of left 0xA5A5A5, LR rising, right 0x3C3C3C, LR falling -> out_valid=1, out_left=0xA5A5A5, out_right=0x3C3C3C, fill_level=1.
REQ-037 SHALL cover: 32 bits per channel, DATA_WIDTH=24, left bits 0xFFFFFF followed by 8 zeros -> out_left=0xFFFFFF (extra bits ignored).
REQ-038 SHALL cover: 16 bits 0xBEEF per channel -> out_left=0xBEEF00.
REQ-039 SHALL cover: 5 frames with out_ready=0 and FIFO_DEPTH=4 -> fill_level=4, overflow=1, head still frame 1; overflow_clear -> overflow=0.
REQ-040 SHALL cover: full FIFO with pop and push in the same cycle -> fill_level=4, overflow=0, new pair at tail.
REQ-041 SHALL cover: reset after 10 left bits, then one full frame -> exactly one entry holding the post-reset frame.

Source files
------------

// File: rtl/audio_in_deserializer.sv
// I2S-style ADC deserializer: captures MSB-first left/right words framed by LR clock
// edge pulses and queues completed stereo pairs in a show-ahead FIFO.
module audio_in_deserializer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bit_clk_rising_edge,
    input  logic                          left_right_clk_rising_edge,
    input  logic                          left_right_clk_falling_edge,
    input  logic                          counting,
    input  logic                          serial_audio_in_data,
    input  logic                          out_ready,
    input  logic                          overflow_clear,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_left,
    output logic [DATA_WIDTH-1:0]         out_right,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow
);

    localparam int IDX_W = $clog2(DATA_WIDTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Capture path state
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
    logic                  left_hold_valid_q, left_hold_valid_d;

    // FIFO state
    logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    overflow_q, overflow_d;

    logic                    sample;
    logic                    index_open;
    logic [DATA_WIDTH-1:0]   bit_sel;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    wr_en;
    logic                    drop;
    logic [2*DATA_WIDTH-1:0] head;

    // A bit landing on an LR edge belongs to neither word and is dropped.
    assign sample     = bit_clk_rising_edge && counting &&
                        !left_right_clk_rising_edge && !left_right_clk_falling_edge;
    assign index_open = (bit_idx_q != IDX_W'(DATA_WIDTH));

    // One-hot select of the shift-word bit addressed by the current bit index
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit_sel
            assign bit_sel[gi] = (bit_idx_q == IDX_W'(DATA_WIDTH - 1 - gi));
        end
    endgenerate

    always_comb begin
        shift_d           = shift_q;
        bit_idx_d         = bit_idx_q;
        left_hold_d       = left_hold_q;
        left_hold_valid_d = left_hold_valid_q;
        push              = 1'b0;
        if (left_right_clk_falling_edge) begin
            push              = left_hold_valid_q;
            left_hold_valid_d = 1'b0;
            shift_d           = '0;
            bit_idx_d         = '0;
        end else if (left_right_clk_rising_edge) begin
            left_hold_d       = shift_q;
            left_hold_valid_d = 1'b1;
            shift_d           = '0;
            bit_idx_d         = '0;
        end else if (sample && index_open) begin
            shift_d   = (shift_q & ~bit_sel) | (bit_sel & {DATA_WIDTH{serial_audio_in_data}});
            bit_idx_d = bit_idx_q + IDX_W'(1);
        end
    end

    assign out_valid = (count_q != '0);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_en     = push && (!full || pop);
    assign drop      = push && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q           <= '0;
            bit_idx_q         <= '0;
            left_hold_q       <= '0;
            left_hold_valid_q <= 1'b0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            overflow_q        <= 1'b0;
        end else begin
            shift_q           <= shift_d;
            bit_idx_q         <= bit_idx_d;
            left_hold_q       <= left_hold_d;
            left_hold_valid_q <= left_hold_valid_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            count_q           <= count_d;
            overflow_q        <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_ptr_q] <= {left_hold_q, shift_q};
        end
    end

    // Show-ahead head: the array is read combinationally so data tracks out_valid.
    assign head       = mem_q[rd_ptr_q];
    assign out_left   = (reset || !out_valid) ? '0 : head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign out_right  = (reset || !out_valid) ? '0 : head[DATA_WIDTH-1:0];
    assign fill_level = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_audio_in_deserializer.sv
// Directed bench for audio_in_deserializer: table of single-frame vectors plus
// hand-written sequences for overflow, same-cycle push/pop, edge-bit and reset cases.
module tb_audio_in_deserializer;

    localparam int DW = 24;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          bce;
    logic          lrr;
    logic          lrf;
    logic          counting;
    logic          sdata;
    logic          out_ready;
    logic          ovc;
    logic          out_valid;
    logic [DW-1:0] out_left;
    logic [DW-1:0] out_right;
    logic [2:0]    fill_level;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    audio_in_deserializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .bit_clk_rising_edge        (bce),
        .left_right_clk_rising_edge (lrr),
        .left_right_clk_falling_edge(lrf),
        .counting                   (counting),
        .serial_audio_in_data       (sdata),
        .out_ready                  (out_ready),
        .overflow_clear             (ovc),
        .out_valid                  (out_valid),
        .out_left                   (out_left),
        .out_right                  (out_right),
        .fill_level                 (fill_level),
        .overflow                   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] left;
        logic [31:0] right;
        int          nbits;
        logic [23:0] exp_left;
        logic [23:0] exp_right;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bce = 1'b0; lrr = 1'b0; lrf = 1'b0; counting = 1'b0;
        sdata = 1'b0; out_ready = 1'b0; ovc = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_out_left", 32'(out_left), 32'h0);
        check("rst_out_right", 32'(out_right), 32'h0);
        tick();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_fill", 32'(fill_level), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        reset = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            bce = 1'b1; counting = 1'b1; sdata = v[n-1-k];
            tick();
            bce = 1'b0; sdata = 1'b0;
            tick();
        end
        counting = 1'b0;
    endtask

    task automatic lr_pulse(input bit rise, input bit with_bit, input bit pop, input bit clr);
        lrr = rise; lrf = !rise;
        bce = with_bit; sdata = with_bit; counting = with_bit;
        out_ready = pop; ovc = clr;
        tick();
        clear_inputs();
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n,
                              input bit pop, input bit clr);
        send_bits(l, n);
        lr_pulse(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(r, n);
        lr_pulse(1'b0, 1'b0, pop, clr);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        vecs[0] = '{32'h00A5A5A5, 32'h003C3C3C, 24, 24'hA5A5A5, 24'h3C3C3C};
        vecs[1] = '{32'hFFFFFF00, 32'h12345678, 32, 24'hFFFFFF, 24'h123456};
        vecs[2] = '{32'h0000BEEF, 32'h0000BEEF, 16, 24'hBEEF00, 24'hBEEF00};
        vecs[3] = '{32'h00000001, 32'h00000000, 1,  24'h800000, 24'h000000};
        tick();

        for (int i = 0; i < 4; i++) begin
            do_reset();
            lr_pulse(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("v%0d_first_fall_fill", i), 32'(fill_level), 32'h0);
            send_bits(vecs[i].left, vecs[i].nbits);
            lr_pulse(1'b1, 1'b0, 1'b0, 1'b0);
            send_bits(vecs[i].right, vecs[i].nbits);
            check($sformatf("v%0d_pre_push_valid", i), 32'(out_valid), 32'h0);
            lr_pulse(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'h1);
            check($sformatf("v%0d_left", i), 32'(out_left), 32'(vecs[i].exp_left));
            check($sformatf("v%0d_right", i), 32'(out_right), 32'(vecs[i].exp_right));
            check($sformatf("v%0d_fill", i), 32'(fill_level), 32'h1);
            pop_one();
            check($sformatf("v%0d_after_pop_valid", i), 32'(out_valid), 32'h0);
        end

        // Overflow: five frames, no consumer
        do_reset();
        lr_pulse(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            send_frame(32'h111111 * i, 32'h100000 + i, 24, 1'b0, 1'b0);
        end
        check("ovf_fill", 32'(fill_level), 32'd4);
        check("ovf_flag", 32'(overflow), 32'h1);
        check("ovf_head_left", 32'(out_left), 32'h111111);
        check("ovf_head_right", 32'(out_right), 32'h100001);
        ovc = 1'b1; tick(); ovc = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'h0);

        // Drop coinciding with overflow_clear: the drop wins
        send_frame(32'h666666, 32'h100006, 24, 1'b0, 1'b1);
        check("drop_wins_flag", 32'(overflow), 32'h1);
        check("drop_wins_fill", 32'(fill_level), 32'd4);
        check("drop_wins_head", 32'(out_left), 32'h111111);
        ovc = 1'b1; tick(); ovc = 1'b0;
        check("drop_wins_cleared", 32'(overflow), 32'h0);

        // Full FIFO, pop and push in the same cycle
        send_frame(32'h777777, 32'h100007, 24, 1'b1, 1'b0);
        check("pp_fill", 32'(fill_level), 32'd4);
        check("pp_ovf", 32'(overflow), 32'h0);
        check("pp_head", 32'(out_left), 32'h222222);
        pop_one(); pop_one(); pop_one();
        check("pp_tail_fill", 32'(fill_level), 32'd1);
        check("pp_tail_left", 32'(out_left), 32'h777777);
        check("pp_tail_right", 32'(out_right), 32'h100007);
        pop_one();
        check("pp_empty_valid", 32'(out_valid), 32'h0);
        pop_one();
        check("empty_pop_fill", 32'(fill_level), 32'h0);

        // Bits coinciding with LR edges are discarded
        do_reset();
        lr_pulse(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(32'hAB, 8);
        lr_pulse(1'b1, 1'b1, 1'b0, 1'b0);
        send_bits(32'h00, 8);
        lr_pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("edge_bit_left", 32'(out_left), 32'hAB0000);
        check("edge_bit_right", 32'(out_right), 32'h000000);

        // Reset mid-word discards the partial frame
        do_reset();
        lr_pulse(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(32'h3FF, 10);
        do_reset();
        lr_pulse(1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(32'h13579B, 32'h2468AC, 24, 1'b0, 1'b0);
        check("midrst_fill", 32'(fill_level), 32'd1);
        check("midrst_left", 32'(out_left), 32'h13579B);
        check("midrst_right", 32'(out_right), 32'h2468AC);
        pop_one();
        check("midrst_empty", 32'(out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
